// File: rtl/pll_rst_seq.sv
// PLL reset and lock sequencer on the free-running reference clock: pulses the PLL
// reset, qualifies lock, releases three domain resets in order, re-arms on loss.
module pll_rst_seq #(
    parameter int RST_PULSE_CYC    = 16,
    parameter int LOCK_TIMEOUT_CYC = 50000,
    parameter int LOCK_STABLE_CYC  = 1024,
    parameter int STAGGER_CYC      = 8,
    parameter int LOSS_FILTER_CYC  = 4,
    parameter int MAX_RETRY        = 7
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       pll_lock_i,
    input  logic       soft_rst_i,
    output logic       pll_rst_o,
    output logic [2:0] dom_rst_n_o,
    output logic       ready_o,
    output logic       fail_o,
    output logic [2:0] retry_cnt_o,
    output logic [2:0] state_o
);

    typedef enum logic [2:0] {
        S_RESET_PLL = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_STABLE    = 3'd2,
        S_RELEASE   = 3'd3,
        S_RUN       = 3'd4,
        S_FAIL      = 3'd5
    } state_t;

    localparam int MAX_A   = (RST_PULSE_CYC > LOCK_TIMEOUT_CYC) ? RST_PULSE_CYC : LOCK_TIMEOUT_CYC;
    localparam int MAX_B   = (LOCK_STABLE_CYC > 2 * STAGGER_CYC) ? LOCK_STABLE_CYC : 2 * STAGGER_CYC;
    localparam int MAX_CYC = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);
    localparam int LOSS_W  = $clog2(LOSS_FILTER_CYC + 1);

    localparam logic [CNT_W-1:0]  PULSE_LAST   = CNT_W'(RST_PULSE_CYC - 1);
    localparam logic [CNT_W-1:0]  TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYC - 1);
    // The WAIT_LOCK cycle that sees lock already counts as the first good sample,
    // so STABLE itself needs LOCK_STABLE_CYC-1 more (LOCK_STABLE_CYC must be >= 2).
    localparam logic [CNT_W-1:0]  STABLE_LAST  = CNT_W'(LOCK_STABLE_CYC - 2);
    localparam logic [CNT_W-1:0]  STAGGER_MARK = CNT_W'(STAGGER_CYC);
    localparam logic [CNT_W-1:0]  RELEASE_LAST = CNT_W'(2 * STAGGER_CYC - 1);
    localparam logic [LOSS_W-1:0] LOSS_LAST    = LOSS_W'(LOSS_FILTER_CYC - 1);
    localparam logic [2:0]        RETRY_MAX    = 3'(MAX_RETRY);

    logic              r_lock_meta;
    logic              r_lock_s;
    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [LOSS_W-1:0] r_loss_cnt;
    logic [2:0]        r_retry;
    logic              r_pll_rst;
    logic [2:0]        r_dom_rst_n;
    logic              r_ready;
    logic              r_fail;

    state_t            w_nxt_state;
    logic [CNT_W-1:0]  w_nxt_cnt;
    logic [LOSS_W-1:0] w_nxt_loss_cnt;
    logic [2:0]        w_nxt_retry;
    logic              w_loss;
    logic              w_fail_attempt;
    logic              w_nxt_pll_rst;
    logic [2:0]        w_nxt_dom_rst_n;
    logic              w_nxt_ready;
    logic              w_nxt_fail;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_lock_meta <= 1'b0;
            r_lock_s    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep the two synchronizer stages distinct;
            // blocking here would collapse them into one flop.
            r_lock_meta <= pll_lock_i;
            r_lock_s    <= r_lock_meta;
        end
    end

    always_comb begin
        // NOTE: every signal gets a default before any branch, so no path can leave
        // one unassigned and infer a latch.
        w_nxt_state    = r_state;
        w_nxt_cnt      = r_cnt;
        w_nxt_loss_cnt = '0;
        w_nxt_retry    = r_retry;
        w_loss         = 1'b0;
        w_fail_attempt = 1'b0;

        if ((r_state == S_RELEASE || r_state == S_RUN) && !r_lock_s) begin
            if (r_loss_cnt == LOSS_LAST) begin
                w_loss = 1'b1;
            end else begin
                w_nxt_loss_cnt = r_loss_cnt + 1'b1;
            end
        end

        case (r_state)
            S_RESET_PLL: begin
                w_nxt_cnt = r_cnt + 1'b1;
                if (r_cnt == PULSE_LAST) w_nxt_state = S_WAIT_LOCK;
            end
            S_WAIT_LOCK: begin
                w_nxt_cnt = r_cnt + 1'b1;
                if (r_lock_s) begin
                    w_nxt_state = S_STABLE;
                end else if (r_cnt == TIMEOUT_LAST) begin
                    w_fail_attempt = 1'b1;
                end
            end
            S_STABLE: begin
                w_nxt_cnt = r_cnt + 1'b1;
                if (!r_lock_s) begin
                    w_nxt_state = S_WAIT_LOCK;
                end else if (r_cnt == STABLE_LAST) begin
                    w_nxt_state = S_RELEASE;
                end
            end
            S_RELEASE: begin
                w_nxt_cnt = r_cnt + 1'b1;
                if (w_loss) begin
                    w_fail_attempt = 1'b1;
                end else if (r_cnt == RELEASE_LAST) begin
                    w_nxt_state = S_RUN;
                end
            end
            S_RUN: begin
                if (w_loss) w_fail_attempt = 1'b1;
            end
            S_FAIL: begin
                w_nxt_state = S_FAIL;
            end
            default: begin
                w_nxt_state = S_RESET_PLL;
            end
        endcase

        if (w_fail_attempt) begin
            w_nxt_retry = r_retry + 3'd1;
            w_nxt_state = (w_nxt_retry == RETRY_MAX) ? S_FAIL : S_RESET_PLL;
        end
        if (w_nxt_state == S_RUN) w_nxt_retry = '0;

        if (soft_rst_i) begin
            w_nxt_state    = S_RESET_PLL;
            w_nxt_retry    = '0;
            w_nxt_loss_cnt = '0;
        end

        // Every state entry, including a soft restart of RESET_PLL, starts from zero.
        if (w_nxt_state != r_state || soft_rst_i) w_nxt_cnt = '0;

        // Outputs are decoded from the next state so they change on the same edge
        // as the transition and leave the block glitch-free from flops.
        w_nxt_pll_rst = (w_nxt_state == S_RESET_PLL) || (w_nxt_state == S_FAIL);
        w_nxt_ready   = (w_nxt_state == S_RUN);
        w_nxt_fail    = (w_nxt_state == S_FAIL);
        case (w_nxt_state)
            S_RUN:     w_nxt_dom_rst_n = 3'b111;
            S_RELEASE: w_nxt_dom_rst_n = {1'b0, (w_nxt_cnt >= STAGGER_MARK), 1'b1};
            default:   w_nxt_dom_rst_n = 3'b000;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state     <= S_RESET_PLL;
            r_cnt       <= '0;
            r_loss_cnt  <= '0;
            r_retry     <= '0;
            r_pll_rst   <= 1'b1;
            r_dom_rst_n <= 3'b000;
            r_ready     <= 1'b0;
            r_fail      <= 1'b0;
        end else begin
            r_state     <= w_nxt_state;
            r_cnt       <= w_nxt_cnt;
            r_loss_cnt  <= w_nxt_loss_cnt;
            r_retry     <= w_nxt_retry;
            r_pll_rst   <= w_nxt_pll_rst;
            r_dom_rst_n <= w_nxt_dom_rst_n;
            r_ready     <= w_nxt_ready;
            r_fail      <= w_nxt_fail;
        end
    end

    assign pll_rst_o   = r_pll_rst;
    assign dom_rst_n_o = r_dom_rst_n;
    assign ready_o     = r_ready;
    assign fail_o      = r_fail;
    assign retry_cnt_o = r_retry;
    assign state_o     = r_state;

endmodule

// File: doc/pll_rst_seq.md
Name: pll_rst_seq

Overview:
- Reset and lock sequencer for the on-chip PLL that produces the ADC/processing clocks.
- Pulses the PLL reset, waits for lock with a timeout, and qualifies lock stability.
- Releases three downstream domain resets in a staggered order, then monitors for lock loss and re-arms the PLL automatically.
- Runs on the free-running board reference clock (50 MHz), never on a PLL output.

Parameters:
- RST_PULSE_CYC, 16: cycles pll_rst_o is held high per PLL reset attempt.
- LOCK_TIMEOUT_CYC, 50000: maximum cycles to wait for the first lock sample after reset (1 ms at 50 MHz).
- LOCK_STABLE_CYC, 1024: consecutive synchronized-lock cycles required before any release.
- STAGGER_CYC, 8: cycles between successive domain reset releases.
- LOSS_FILTER_CYC, 4: consecutive unlocked cycles that count as a lock loss.
- MAX_RETRY, 7: failed attempts before entering FAIL; range 1..7.

Ports:
- sys_clk  in  1  reference clock, 50 MHz, free-running.
- sys_rst_n  in  1  asynchronous active-low reset.
- pll_lock_i  in  1  PLL lock, asynchronous to sys_clk.
- soft_rst_i  in  1  single-cycle request to restart the full sequence.
- pll_rst_o  out  1  PLL reset, active high.
- dom_rst_n_o  out  3  domain resets, active low; bit0 released first.
- ready_o  out  1  all domains out of reset, PLL locked.
- fail_o  out  1  retry budget exhausted.
- retry_cnt_o  out  3  failed attempts since the last RUN entry or restart.
- state_o  out  3  FSM state encoding for debug.

Behaviour:
- Async reset values: pll_rst_o=1, dom_rst_n_o=3'b000, ready_o=0, fail_o=0, retry_cnt_o=0, state=RESET_PLL.
- pll_lock_i passes through a 2-flop synchronizer to give lock_s. All decisions use lock_s, so there is a 2-cycle input latency.
- State encodings: RESET_PLL=0, WAIT_LOCK=1, STABLE=2, RELEASE=3, RUN=4, FAIL=5.
- RESET_PLL: pll_rst_o=1 for exactly RST_PULSE_CYC cycles, then go to WAIT_LOCK. pll_rst_o=0 in every state except RESET_PLL and FAIL.
- WAIT_LOCK: the counter starts at 0.
  - lock_s=1 -> STABLE.
  - Counter reaches LOCK_TIMEOUT_CYC-1 with lock_s=0 -> timeout.
- STABLE: counts consecutive lock_s=1 cycles.
  - Any lock_s=0 -> WAIT_LOCK, with the timeout counter restarted.
  - Count reaches LOCK_STABLE_CYC -> RELEASE.
- RELEASE:
  - dom_rst_n_o[0]=1 on the first RELEASE cycle.
  - dom_rst_n_o[1]=1 STAGGER_CYC cycles later.
  - dom_rst_n_o[2]=1 2*STAGGER_CYC cycles later, on the same edge as the transition to RUN.
  - ready_o=1 throughout RUN only. retry_cnt clears on entry to RUN.
- Loss: in RELEASE or RUN, lock_s=0 for LOSS_FILTER_CYC consecutive cycles is a loss. Shorter glitches are ignored and reset the filter count. On loss, on the same edge:
  - dom_rst_n_o=000 and ready_o=0.
  - Treated as a failed attempt.
- Failed attempt (timeout or loss): retry_cnt+1.
  - If the new value equals MAX_RETRY -> FAIL.
  - Otherwise -> RESET_PLL.
- FAIL: pll_rst_o=1, dom_rst_n_o=000, fail_o=1. The only exits are soft_rst_i or sys_rst_n.
- soft_rst_i in any state, with priority over all other transitions:
  - Next state RESET_PLL, RST_PULSE_CYC counter restarted.
  - retry_cnt=0, fail_o=0.
  - dom_rst_n_o=000 and ready_o=0 on the same edge.
- soft_rst_i during RESET_PLL restarts the pulse, which extends it.
- Domain reset bits are only ever deasserted in ascending order. They are all reasserted together.
- Counters are sized with $clog2 of the largest parameter and never wrap: each counter clears on state entry.

Test Plan (RST_PULSE_CYC=4, LOCK_TIMEOUT_CYC=20, LOCK_STABLE_CYC=8, STAGGER_CYC=3, LOSS_FILTER_CYC=2, MAX_RETRY=2):
- Nominal: release sys_rst_n; pll_lock_i rises 5 cycles after pll_rst_o falls -> pll_rst_o high exactly 4 cycles; dom_rst_n_o goes 001, 011, 111 at 3-cycle spacing, starting 8 cycles after lock_s rises; ready_o=1 with 111; retry_cnt_o=0.
- Glitch filter: in RUN, drop pll_lock_i for 1 cycle -> no change. Drop it for 3 cycles -> dom_rst_n_o=000 and ready_o=0 two cycles after lock_s falls; pll_rst_o pulses 4 cycles; retry_cnt_o=1.
- Timeout/fail: hold pll_lock_i=0 -> two 20-cycle waits, each preceded by a 4-cycle pll_rst_o pulse -> fail_o=1, pll_rst_o=1, state_o=5, retry_cnt_o=2.
- Stability restart: in STABLE, drop lock after 5 good cycles -> state_o returns to 1; no dom_rst_n_o bit releases until 8 consecutive good cycles are seen.
- Soft restart: pulse soft_rst_i in FAIL and again mid-RELEASE with dom_rst_n_o=011 -> next edge gives dom_rst_n_o=000, fail_o=0, retry_cnt_o=0, state_o=0; the nominal sequence then repeats.
- Async reset mid-RUN: assert sys_rst_n between clock edges -> all outputs take their reset values immediately, without waiting for a clock edge.
